// File: rtl/tagger_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tagger_pkg
//  Description : Shared tag-word format used by both tagger encoder and
//                decoder: word-type codes, field positions, counter width.
//  Revision    : 1.0 - initial release
// ============================================================================
package tagger_pkg;

    localparam int COUNTER_BITS = 16;

    localparam logic [1:0] TAG_EVENT    = 2'b00;
    localparam logic [1:0] TAG_ROLLOVER = 2'b01;
    localparam logic [1:0] TAG_OVERFLOW = 2'b10;
    localparam logic [1:0] TAG_RESERVED = 2'b11;

    localparam int TYPE_MSB = 31;
    localparam int TYPE_LSB = 30;
    localparam int CHAN_MSB = 29;
    localparam int CHAN_LSB = 24;
    localparam int SUB_MSB  = 23;
    localparam int SUB_LSB  = 16;
    localparam int CNT_MSB  = 15;
    localparam int CNT_LSB  = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } dec_state_t;

    function automatic logic [1:0] tag_type(input logic [31:0] word);
        return word[TYPE_MSB:TYPE_LSB];
    endfunction

endpackage
`default_nettype wire

// File: rtl/tagger_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tagger_sat_counter
//  Description : Counter of COUNTER_BITS width that sticks at all-ones;
//                clear has priority over increment.
//  Revision    : 1.0 - initial release
// ============================================================================
module tagger_sat_counter
    import tagger_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr_i,
    input  logic                    inc_i,
    output logic [COUNTER_BITS-1:0] count_o
);

    logic [COUNTER_BITS-1:0] count_q;
    logic [COUNTER_BITS-1:0] count_d;
    logic                    w_at_max;

    assign w_at_max = &count_q;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && !w_at_max) begin
            count_d = count_q + COUNTER_BITS'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/tagger_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tagger_decoder
//  Description : Drains tag words from the FIFO, tracks the rollover epoch and
//                presents absolute-time events on a valid/ready stream.
//                Optional: TAGGER_DECODER_MONOTONIC_CHECK_EN flags backwards
//                timestamps.
//  Revision    : 1.0 - initial release
// ============================================================================
module tagger_decoder
    import tagger_pkg::*;
#(
    parameter int CHANNELS   = 1,
    parameter int BITS       = 1,
    parameter int EPOCH_BITS = 32
)
(
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               read_empty,
    output logic                               read_enable,
    input  logic [31:0]                        read_data,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [5:0]                         out_channel,
    output logic [EPOCH_BITS+COUNTER_BITS+BITS-1:0] out_time,
    output logic                               out_after_overflow,
    output logic                               overflow_flag,
    input  logic                               overflow_clear,
    output logic [COUNTER_BITS-1:0]            overflow_count,
    output logic [COUNTER_BITS-1:0]            error_count
);

    localparam int         TIME_W       = EPOCH_BITS + COUNTER_BITS + BITS;
    localparam logic [6:0] c_CHAN_LIMIT = 7'(CHANNELS);

    dec_state_t                 state_q;
    logic [EPOCH_BITS-1:0]      epoch_q;
    logic                       pend_ovf_q;
    logic                       out_valid_q;
    logic [5:0]                 out_channel_q;
    logic [TIME_W-1:0]          out_time_q;
    logic                       after_ovf_q;
    logic                       ovf_flag_q;

    logic [1:0]                 w_type;
    logic [5:0]                 w_chan;
    logic [BITS-1:0]            w_sub;
    logic [COUNTER_BITS-1:0]    w_cnt;
    logic                       w_chan_ok;
    logic [TIME_W-1:0]          w_time;
    logic                       w_in_wait;
    logic                       w_read;
    logic                       w_emit;
    logic                       w_backwards;
    logic                       w_ovf_word;
    logic                       w_err_inc;
    logic                       w_unused_sub_bits;

    // Upper subtime bits beyond BITS carry no information for this build.
    assign w_unused_sub_bits = &{1'b0, read_data[SUB_MSB:SUB_LSB]};

    assign w_type    = tag_type(read_data);
    assign w_chan    = read_data[CHAN_MSB:CHAN_LSB];
    assign w_sub     = read_data[SUB_LSB +: BITS];
    assign w_cnt     = read_data[CNT_MSB:CNT_LSB];
    assign w_chan_ok = {1'b0, w_chan} < c_CHAN_LIMIT;
    assign w_time    = {epoch_q, w_cnt, w_sub};

    assign w_in_wait  = (state_q == ST_WAIT);
    assign w_read     = !rst && (state_q == ST_IDLE) && !read_empty && !out_valid_q;
    assign w_emit     = w_in_wait && (w_type == TAG_EVENT) && w_chan_ok;
    assign w_ovf_word = w_in_wait && (w_type == TAG_OVERFLOW);
    assign w_err_inc  = w_in_wait && (((w_type == TAG_EVENT) && !w_chan_ok)
                                      || (w_type == TAG_RESERVED)
                                      || (w_emit && w_backwards));

`ifdef TAGGER_DECODER_MONOTONIC_CHECK_EN
    logic [TIME_W-1:0] last_time_q;

    // Equal times are legal: several channels can share one counter value.
    assign w_backwards = (w_time < last_time_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            last_time_q <= '0;
        end else if (w_emit) begin
            last_time_q <= w_time;
        end
    end
`else
    assign w_backwards = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            epoch_q       <= '0;
            pend_ovf_q    <= 1'b0;
            out_valid_q   <= 1'b0;
            out_channel_q <= '0;
            out_time_q    <= '0;
            after_ovf_q   <= 1'b0;
            ovf_flag_q    <= 1'b0;
        end else begin
            // A fresh overflow word beats a simultaneous clear.
            if (w_ovf_word) begin
                ovf_flag_q <= 1'b1;
            end else if (overflow_clear) begin
                ovf_flag_q <= 1'b0;
            end

            case (state_q)
                ST_IDLE: begin
                    if (w_read) begin
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    state_q <= ST_IDLE;
                    case (w_type)
                        TAG_EVENT: begin
                            if (w_chan_ok) begin
                                out_channel_q <= w_chan;
                                out_time_q    <= w_time;
                                after_ovf_q   <= pend_ovf_q | w_backwards;
                                pend_ovf_q    <= 1'b0;
                                out_valid_q   <= 1'b1;
                                state_q       <= ST_HOLD;
                            end
                        end
                        TAG_ROLLOVER: begin
                            epoch_q <= epoch_q + EPOCH_BITS'(1);
                        end
                        TAG_OVERFLOW: begin
                            pend_ovf_q <= 1'b1;
                        end
                        default: begin
                        end
                    endcase
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    tagger_sat_counter u_ovf_count (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (1'b0),
        .inc_i   (w_ovf_word),
        .count_o (overflow_count)
    );

    tagger_sat_counter u_err_count (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (1'b0),
        .inc_i   (w_err_inc),
        .count_o (error_count)
    );

    assign read_enable        = w_read;
    assign out_valid          = out_valid_q;
    assign out_channel        = out_channel_q;
    assign out_time           = out_time_q;
    assign out_after_overflow = after_ovf_q;
    assign overflow_flag      = ovf_flag_q;

endmodule
`default_nettype wire

// File: tb/tb_tagger_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tagger_decoder
//  Description : Directed bench for tagger_decoder with a FIFO model and a
//                word-level reference model of the decoded event stream.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tagger_decoder;

    localparam int P_CH    = 4;
    localparam int P_BITS  = 1;
    localparam int P_EPOCH = 4;
    localparam int TW      = P_EPOCH + 16 + P_BITS;

    typedef struct packed {
        logic [5:0]    ch;
        logic [TW-1:0] t;
        logic          af;
    } ev_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          read_empty = 1'b1;
    logic          read_enable;
    logic [31:0]   read_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [5:0]    out_channel;
    logic [TW-1:0] out_time;
    logic          out_after_overflow;
    logic          overflow_flag;
    logic          overflow_clear = 1'b0;
    logic [15:0]   overflow_count;
    logic [15:0]   error_count;

    always #5 clk = ~clk;

    tagger_decoder #(
        .CHANNELS   (P_CH),
        .BITS       (P_BITS),
        .EPOCH_BITS (P_EPOCH)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .read_empty         (read_empty),
        .read_enable        (read_enable),
        .read_data          (read_data),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .out_channel        (out_channel),
        .out_time           (out_time),
        .out_after_overflow (out_after_overflow),
        .overflow_flag      (overflow_flag),
        .overflow_clear     (overflow_clear),
        .overflow_count     (overflow_count),
        .error_count        (error_count)
    );

    int n_cmp = 0;
    int n_err = 0;
    int re_cnt = 0;
    int n_hs = 0;

    logic [31:0] fifo[$];
    ev_t         exp_q[$];
    ev_t         seen_q[$];
    ev_t         last_seen = '0;

    int            m_epoch = 0;
    int            m_pend  = 0;
    int            m_ovf   = 0;
    int            m_err   = 0;
    int            m_flag  = 0;
    logic [TW-1:0] m_last  = '0;

    // FIFO with one-cycle read latency; empty flag updates on the clock.
    always @(posedge clk) begin
        if (read_enable) begin
            re_cnt <= re_cnt + 1;
            if (fifo.size() != 0) read_data <= fifo.pop_front();
        end
        read_empty <= (fifo.size() == 0);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: timed out waiting, required event never occurred", name);
    endtask

    function automatic int sat_inc(input int v);
        return (v < 65535) ? v + 1 : v;
    endfunction

    function automatic logic [31:0] ev_word(input int ch, input int sub, input int cnt);
        logic [31:0] w;
        w = {2'b00, 6'(ch), 8'(sub), 16'(cnt)};
        return w;
    endfunction

    localparam logic [31:0] ROLL = 32'h4ABC_1234;
    localparam logic [31:0] OVF  = 32'h8000_FFFF;
    localparam logic [31:0] RSV  = 32'hC123_4567;

    // Reference model: words are interpreted in FIFO order as they are queued.
    task automatic push(input logic [31:0] w);
        ev_t    e;
        longint t;
        int     ch;
        ch = int'(w[29:24]);
        case (w[31:30])
            2'b00: begin
                if (ch < P_CH) begin
                    t = longint'(m_epoch) * (longint'(1) << (16 + P_BITS))
                      + longint'(w[15:0]) * (longint'(1) << P_BITS)
                      + (longint'(w[23:16]) % (longint'(1) << P_BITS));
                    e.ch = w[29:24];
                    e.t  = TW'(t);
                    e.af = (m_pend != 0);
                    m_pend = 0;
`ifdef TAGGER_DECODER_MONOTONIC_CHECK_EN
                    if (e.t < m_last) begin
                        e.af  = 1'b1;
                        m_err = sat_inc(m_err);
                    end
                    m_last = e.t;
`endif
                    exp_q.push_back(e);
                end else begin
                    m_err = sat_inc(m_err);
                end
            end
            2'b01: m_epoch = (m_epoch + 1) % (1 << P_EPOCH);
            2'b10: begin
                m_flag = 1;
                m_pend = 1;
                m_ovf  = sat_inc(m_ovf);
            end
            default: m_err = sat_inc(m_err);
        endcase
        fifo.push_back(w);
    endtask

    // Every cycle an event is presented it must match the head of the model.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (exp_q.size() == 0) begin
                timeout_fail("unexpected_event");
            end else begin
                check("event", 64'({out_channel, out_time, out_after_overflow}), 64'(exp_q[0]));
                if (out_ready) begin
                    last_seen = {out_channel, out_time, out_after_overflow};
                    seen_q.push_back(last_seen);
                    n_hs++;
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_idle(input string name);
        int stable;
        bit done;
        stable = 0;
        done = 0;
        for (int i = 0; i < 400 && !done; i++) begin
            tick();
            if (fifo.size() == 0 && !out_valid && !read_enable) stable++;
            else stable = 0;
            if (stable >= 4) done = 1;
        end
        if (!done) timeout_fail(name);
        check({name, "_drained"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int  re0, f0, hs0;
        ev_t d0;
        bit  got;

        // Reset: a word is already queued but nothing may be read.
        rst = 1'b1;
        push(ev_word(3, 1, 16'h1234));
        repeat (3) tick();
        check("rst_read_enable", 64'(read_enable), 64'd0);
        check("rst_out_valid",   64'(out_valid), 64'd0);
        check("rst_out_channel", 64'(out_channel), 64'd0);
        check("rst_out_time",    64'(out_time), 64'd0);
        check("rst_after_ovf",   64'(out_after_overflow), 64'd0);
        check("rst_ovf_flag",    64'(overflow_flag), 64'd0);
        check("rst_ovf_count",   64'(overflow_count), 64'd0);
        check("rst_err_count",   64'(error_count), 64'd0);

        // Single event.
        rst = 1'b0;
        wait_idle("single");
        check("single_reads", 64'(re_cnt), 64'd1);
        check("single_hs",    64'(n_hs), 64'd1);
        check("single_time",  64'(last_seen.t), 64'({4'h0, 16'h1234, 1'b1}));
        check("single_ch",    64'(last_seen.ch), 64'd3);

        // Two rollovers then an event.
        push(ROLL);
        push(ROLL);
        push(ev_word(0, 0, 16'h0005));
        wait_idle("rollover");
        check("roll_epoch", 64'(last_seen.t[TW-1 -: P_EPOCH]), 64'd2);
        check("roll_cnt",   64'(last_seen.t[16:1]), 64'h5);

        // Overflow marker then two events.
        seen_q.delete();
        push(OVF);
        push(ev_word(1, 1, 16'h0010));
        push(ev_word(2, 0, 16'h0010));
        wait_idle("overflow");
        check("ovf_seen",   64'(seen_q.size()), 64'd2);
        if (seen_q.size() == 2) begin
            check("ovf_first_af",  64'(seen_q[0].af), 64'd1);
            check("ovf_second_af", 64'(seen_q[1].af), 64'd0);
        end
        check("ovf_flag",  64'(overflow_flag), 64'd1);
        check("ovf_count", 64'(overflow_count), 64'd1);
        overflow_clear = 1'b1;
        tick();
        overflow_clear = 1'b0;
        m_flag = 0;
        tick();
        check("ovf_flag_cleared", 64'(overflow_flag), 64'(m_flag));
        check("ovf_count_kept",   64'(overflow_count), 64'd1);

        // Backpressure: consumer stalls for 10 cycles.
        out_ready = 1'b0;
        push(ev_word(2, 0, 16'h0020));
        push(ev_word(3, 1, 16'h0021));
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            if (out_valid) got = 1;
        end
        if (!got) timeout_fail("stall_valid");
        re0 = re_cnt;
        f0  = fifo.size();
        d0  = {out_channel, out_time, out_after_overflow};
        check("stall_fifo_level", 64'(f0), 64'd1);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("stall_valid", 64'(out_valid), 64'd1);
            check("stall_data",  64'({out_channel, out_time, out_after_overflow}), 64'(d0));
            check("stall_reads", 64'(re_cnt), 64'(re0));
            check("stall_fifo",  64'(fifo.size()), 64'(f0));
        end
        out_ready = 1'b1;
        wait_idle("stall");

        // Bad channel and a reserved word.
        hs0 = n_hs;
        push(ev_word(7, 0, 16'h0001));
        push(RSV);
        wait_idle("errors");
        check("err_count",       64'(error_count), 64'd2);
        check("err_count_model", 64'(error_count), 64'(m_err));
        check("err_no_event",    64'(n_hs), 64'(hs0));

        // Epoch wrap: 2 + 14 rollovers lands on 0, a further 16 return to 0.
        for (int i = 0; i < 14; i++) push(ROLL);
        push(ev_word(0, 1, 16'h0009));
        wait_idle("wrap1");
        check("wrap1_time", 64'(last_seen.t), 64'({4'h0, 16'h0009, 1'b1}));
        for (int i = 0; i < 16; i++) push(ROLL);
        push(ev_word(1, 0, 16'h0003));
        wait_idle("wrap2");
        check("wrap2_time", 64'(last_seen.t), 64'({4'h0, 16'h0003, 1'b0}));
        check("wrap_ovf_count", 64'(overflow_count), 64'(m_ovf));

        // Reset while the decoder sits in WAIT.
        push(ROLL);
        push(ev_word(1, 1, 16'h0077));
        wait_idle("pre_rst");
        push(ev_word(2, 1, 16'h0077));
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            if (read_enable) got = 1;
        end
        if (!got) timeout_fail("rst_wait_read");
        tick();
        re0 = re_cnt;
        rst = 1'b1;
        exp_q.delete();
        m_epoch = 0;
        m_pend  = 0;
        m_ovf   = 0;
        m_err   = 0;
        m_flag  = 0;
        m_last  = '0;
        tick();
        check("rstw_out_valid",   64'(out_valid), 64'd0);
        check("rstw_out_channel", 64'(out_channel), 64'd0);
        check("rstw_out_time",    64'(out_time), 64'd0);
        check("rstw_after_ovf",   64'(out_after_overflow), 64'd0);
        check("rstw_ovf_flag",    64'(overflow_flag), 64'd0);
        check("rstw_ovf_count",   64'(overflow_count), 64'd0);
        check("rstw_err_count",   64'(error_count), 64'd0);
        check("rstw_read_enable", 64'(read_enable), 64'd0);
        rst = 1'b0;
        hs0 = n_hs;
        repeat (8) tick();
        check("rstw_no_event", 64'(n_hs), 64'(hs0));
        check("rstw_no_reread", 64'(re_cnt), 64'(re0));

        // Epoch restarts at 0 after reset.
        push(ev_word(2, 1, 16'h00AA));
        wait_idle("post_rst");
        check("post_rst_time", 64'(last_seen.t), 64'({4'h0, 16'h00AA, 1'b1}));
        check("post_rst_ch",   64'(last_seen.ch), 64'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
